func_gen_checker: RTL and testbench
===================================

# func_gen_checker

Hardware self-test sequencer for the `function_generator` block. On `start` it drives the generator's `A`, `B` and `sel` inputs through all 32 combinations, samples `F` after a settle window, and assembles the observed 32-bit truth table. It then compares that table against a golden table and reports the pass/fail result, the mismatch count and the first failing index. It sits beside a `function_generator` instance as its on-chip stimulus/response partner, replacing the simulation-only sweep.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: number of clock cycles each vector is held before `F` is sampled. Legal range is 1..15, held in a 4-bit counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a sweep; sampled only in IDLE.
- `expected`  input  32  golden truth table; latched on the accepted start.
- `F`  input  1  function_generator output under test.
- `A`  output  1  stimulus A; equals `idx[1]`.
- `B`  output  1  stimulus B; equals `idx[0]`.
- `sel`  output  3  stimulus select; equals `idx[4:2]`.
- `busy`  output  1  high while the sweep is in progress.
- `done`  output  1  one-cycle pulse when the sweep completes.
- `pass`  output  1  1 when the last sweep had zero mismatches.
- `table_out`  output  32  observed table; bit `{sel,A,B}` holds the sampled `F`.
- `mismatch_cnt`  output  6  number of mismatching bits, range 0..32.
- `first_fail`  output  5  index of the lowest mismatching bit.
- `fail_seen`  output  1  1 when `first_fail` is valid.

## Operation
- States: IDLE, WAIT, DONE.
- **Reset** (asynchronous, any state): go to IDLE. `idx`=0, so `A`=`B`=0 and `sel`=0. `busy`=`done`=`pass`=`fail_seen`=0. `table_out`=0, `mismatch_cnt`=0, `first_fail`=0. Latched expected=0. Settle counter=0.
- **IDLE**, `start`=1: latch `expected`, set `idx`=0, clear `table_out`, `mismatch_cnt`, `first_fail`, `fail_seen` and `pass`, load the settle counter with `SETTLE_CYCLES`-1, and go to WAIT. With `start`=0, hold everything; results from the previous sweep stay visible.
- **WAIT**: `busy`=1. While the counter is nonzero, decrement it. When the counter is 0:
  - write `F` into `table_out[idx]`.
  - if `F` != latched `expected[idx]`: increment `mismatch_cnt`. If `fail_seen`=0, set `first_fail`=`idx` and `fail_seen`=1.
  - if `idx`=31, go to DONE; otherwise increment `idx` and reload the counter.
- **DONE**, for one cycle: `done`=1, `busy`=0, `pass` = (`mismatch_cnt`==0). Then go to IDLE unconditionally.
- Sweep order is `sel` outer, `{A,B}` inner: 00, 01, 10, 11 per `sel` value, with `sel` running 0..7.
- `start` is ignored in WAIT and DONE; no queuing.
- `idx` stays at 31 after the sweep, so the outputs hold `A`=`B`=1 and `sel`=7 until the next start.
- `F` is compared with equality; X/Z on `F` is out of contract.

## Timing
- Let the accepting edge be T. The first vector is driven from T, and each vector is held for `SETTLE_CYCLES` cycles.
- Vector k is sampled on edge T+(k+1)·`SETTLE_CYCLES`.
- `done` is high in the cycle after edge T+32·`SETTLE_CYCLES`, i.e. 32·S+1 cycles after the start edge. For S=1 that is 33 cycles.
- `pass` is valid from the `done` cycle and holds until the next accepted start.
- `mismatch_cnt`, `first_fail` and `table_out` update one sample at a time and are final at `done`.
- With `start` held high continuously, a new sweep is accepted on the first IDLE cycle after DONE, giving a 1-cycle gap between sweeps.
- Reset mid-sweep aborts immediately with no `done` pulse; the next start begins at `idx`=0.
- Stimulus outputs change only on clock edges; the device under test sees `SETTLE_CYCLES` full cycles per vector.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle → all outputs 0 asynchronously; release → IDLE, `busy`=0.
- **Good sweep:** S=1, golden model AND/OR/XOR/NAND/NOR/XNOR/~A/~B for `sel`=0..7, `expected`=32'h539176E8 → `{sel,A,B}` steps 0..31 one per cycle, `done` 33 cycles after start, `table_out`=32'h539176E8, `mismatch_cnt`=0, `pass`=1, `fail_seen`=0.
- **Fault injection:** same expected table, model with `sel`=2 output stuck at 0 → `table_out`=32'h539170E8, `mismatch_cnt`=2, `first_fail`=9, `fail_seen`=1, `pass`=0.
- **Start handling:** pulse `start` at `idx`=5 → ignored, `done` timing unchanged. Then hold `start` high through `done` → a new sweep is accepted one cycle after `done` and results clear.
- **Reset mid-sweep:** assert `rst_n` at `idx`=12 → no `done`. Restart → full 33-cycle sweep from `idx`=0.
- **Settle window:** S=3, model with a 2-cycle `F` delay → each vector held 3 cycles, `done` 97 cycles after start, `pass`=1. With S=1 and the same delayed model → `pass`=0.

Source files
------------

// File: rtl/func_gen_checker.sv
// Self-test sequencer: sweeps {sel,A,B} over 32 vectors, samples F, compares with a golden table.
// Latency: 32*SETTLE_CYCLES+1 cycles from accepted start to done; start is ignored while a sweep runs.
// Backpressure: none; start is sampled only in IDLE and is not queued.
module func_gen_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] expected,
    input  logic        F,
    output logic        A,
    output logic        B,
    output logic [2:0]  sel,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] table_out,
    output logic [5:0]  mismatch_cnt,
    output logic [4:0]  first_fail,
    output logic        fail_seen
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [4:0]  idx;
    logic [3:0]  settle_cnt;
    logic [31:0] exp_q;
    logic        miss;
    logic [5:0]  mismatch_next;

    assign miss          = (F != exp_q[idx]);
    assign mismatch_next = mismatch_cnt + {5'd0, miss};

    assign B    = idx[0];
    assign A    = idx[1];
    assign sel  = idx[4:2];
    assign busy = (state == ST_WAIT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= 5'd0;
            settle_cnt   <= 4'd0;
            exp_q        <= 32'd0;
            table_out    <= 32'd0;
            mismatch_cnt <= 6'd0;
            first_fail   <= 5'd0;
            fail_seen    <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        idx          <= 5'd0;
                        table_out    <= 32'd0;
                        mismatch_cnt <= 6'd0;
                        first_fail   <= 5'd0;
                        fail_seen    <= 1'b0;
                        pass         <= 1'b0;
                        settle_cnt   <= SETTLE_RELOAD;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        table_out[idx] <= F;
                        mismatch_cnt   <= mismatch_next;
                        if (miss && !fail_seen) begin
                            first_fail <= idx;
                            fail_seen  <= 1'b1;
                        end
                        // pass is resolved on the last sample so it is already valid while done is high
                        if (idx == 5'd31) begin
                            pass  <= (mismatch_next == 6'd0);
                            state <= ST_DONE;
                        end else begin
                            idx        <= idx + 5'd1;
                            settle_cnt <= SETTLE_RELOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_func_gen_checker.sv
// Scoreboard bench: two checker instances (S=1, S=3) each driving a behavioural function generator model.
module tb_func_gen_checker;

    localparam logic [31:0] GOOD  = 32'h539176E8;
    localparam logic [31:0] FAULT = 32'h539170E8;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mode = 0;   // 0 golden, 1 sel=2 stuck at 0, 2 F delayed by two cycles

    logic        start1, a1, b1, f1, busy1, done1, pass1, fs1;
    logic [2:0]  sel1;
    logic [31:0] exp1, tbl1;
    logic [5:0]  mc1;
    logic [4:0]  ff1;
    logic        start3, a3, b3, f3, busy3, done3, pass3, fs3;
    logic [2:0]  sel3;
    logic [31:0] exp3, tbl3;
    logic [5:0]  mc3;
    logic [4:0]  ff3;
    logic        d1_1, d2_1, d1_3, d2_3;

    func_gen_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .F(f1),
        .A(a1), .B(b1), .sel(sel1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tbl1), .mismatch_cnt(mc1), .first_fail(ff1), .fail_seen(fs1)
    );

    func_gen_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .F(f3),
        .A(a3), .B(b3), .sel(sel3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(tbl3), .mismatch_cnt(mc3), .first_fail(ff3), .fail_seen(fs3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic golden(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0: golden = a & b;
            3'd1: golden = a | b;
            3'd2: golden = a ^ b;
            3'd3: golden = ~(a & b);
            3'd4: golden = ~(a | b);
            3'd5: golden = ~(a ^ b);
            3'd6: golden = ~a;
            default: golden = ~b;
        endcase
    endfunction

    always @(posedge clk) begin
        d1_1 <= golden(sel1, a1, b1);
        d2_1 <= d1_1;
        d1_3 <= golden(sel3, a3, b3);
        d2_3 <= d1_3;
    end

    assign f1 = (mode == 2) ? d2_1 : ((mode == 1) && (sel1 == 3'd2)) ? 1'b0 : golden(sel1, a1, b1);
    assign f3 = (mode == 2) ? d2_3 : ((mode == 1) && (sel3 == 3'd2)) ? 1'b0 : golden(sel3, a3, b3);

    typedef struct {
        bit          i3;
        bit          full;
        logic [31:0] tbl;
        logic [5:0]  mc;
        logic [4:0]  ff;
        logic        fs;
        logic        ps;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_done(input bit i3, input bit full, input logic [31:0] tbl, input logic [5:0] mc,
                               input logic [4:0] ff, input logic fs, input logic ps, input int dc);
        exp_t e;
        e.i3 = i3; e.full = full; e.tbl = tbl; e.mc = mc;
        e.ff = ff; e.fs = fs; e.ps = ps; e.done_cyc = dc;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done1 || done3)) begin
            if (sb.size() == 0) begin
                check("spurious_done", {30'd0, done3, done1}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_inst", {31'd0, done3}, {31'd0, e.i3});
                check("done_cycle", cyc, e.done_cyc);
                check("pass", e.i3 ? pass3 : pass1, e.ps);
                check("busy_at_done", e.i3 ? busy3 : busy1, 0);
                if (e.full) begin
                    check("table_out", e.i3 ? tbl3 : tbl1, e.tbl);
                    check("mismatch_cnt", e.i3 ? mc3 : mc1, e.mc);
                    check("first_fail", e.i3 ? ff3 : ff1, e.ff);
                    check("fail_seen", e.i3 ? fs3 : fs1, e.fs);
                end
            end
        end
    end

    // Raises start for one cycle; c is the cycle in which start is sampled.
    task automatic issue(input bit i3, input logic [31:0] tbl, output int c);
        @(negedge clk);
        if (i3) begin exp3 = tbl; start3 = 1'b1; end
        else    begin exp1 = tbl; start1 = 1'b1; end
        c = cyc;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Walks every cycle of a sweep checking the presented vector; optionally pulses start mid-sweep.
    task automatic vectors(input bit i3, input int s, input int pulse_at);
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < s; j++) begin
                check("vec_idx", i3 ? {27'd0, sel3, a3, b3} : {27'd0, sel1, a1, b1}, k);
                if (!i3) start1 = (k == pulse_at) && (j == 0);
                @(negedge clk);
            end
        end
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input bit i3);
        int n = 0;
        while (((i3 ? busy3 : busy1) || (i3 ? done3 : done1)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, n < 300}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_zero1(input string tag);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_pass"}, pass1, 0);
        check({tag, "_table"}, tbl1, 0);
        check({tag, "_mcnt"}, mc1, 0);
        check({tag, "_ff"}, ff1, 0);
        check({tag, "_fs"}, fs1, 0);
        check({tag, "_vec"}, {27'd0, sel1, a1, b1}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b1;
        start1 = 1'b0; start3 = 1'b0;
        exp1 = 32'd0;  exp3 = 32'd0;
        #1 rst_n = 1'b0;
        #2;
        check_zero1("rst0");
        check("rst0_busy3", busy3, 0);
        check("rst0_table3", tbl3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy1, 0);

        // Good sweep, S=1
        mode = 0;
        issue(0, GOOD, c);
        expect_done(0, 1, GOOD, 6'd0, 5'd0, 1'b0, 1'b1, c + 33);
        vectors(0, 1, -1);
        wait_idle(0);
        check("hold_vec", {27'd0, sel1, a1, b1}, 31);
        check("hold_pass", pass1, 1);

        // Fault on sel=2, with a start pulse at idx 5 that must be ignored
        mode = 1;
        issue(0, GOOD, c);
        expect_done(0, 1, FAULT, 6'd2, 5'd9, 1'b1, 1'b0, c + 33);
        vectors(0, 1, 5);
        wait_idle(0);

        // start held through done: second sweep accepted in the IDLE cycle after done
        mode = 1;
        @(negedge clk);
        exp1 = GOOD;
        start1 = 1'b1;
        c = cyc;
        expect_done(0, 1, FAULT, 6'd2, 5'd9, 1'b1, 1'b0, c + 33);
        expect_done(0, 1, GOOD, 6'd0, 5'd0, 1'b0, 1'b1, c + 67);
        repeat (33) @(negedge clk);
        mode = 0;
        @(negedge clk);
        check("gap_busy", busy1, 0);
        check("gap_mcnt", mc1, 2);
        @(negedge clk);
        check("restart_busy", busy1, 1);
        check("restart_mcnt", mc1, 0);
        check("restart_fs", fs1, 0);
        check("restart_table", tbl1, 0);
        check("restart_vec", {27'd0, sel1, a1, b1}, 0);
        start1 = 1'b0;
        wait_idle(0);

        // Asynchronous reset while results are visible
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero1("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-sweep at idx 12: no done, then a clean full sweep
        mode = 0;
        issue(0, GOOD, c);
        repeat (12) @(negedge clk);
        check("abort_vec", {27'd0, sel1, a1, b1}, 12);
        #2 rst_n = 1'b0;
        #1 check_zero1("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_busy", busy1, 0);
        issue(0, GOOD, c);
        expect_done(0, 1, GOOD, 6'd0, 5'd0, 1'b0, 1'b1, c + 33);
        vectors(0, 1, -1);
        wait_idle(0);

        // Delayed F with S=3 settles in time
        mode = 2;
        issue(1, GOOD, c);
        expect_done(1, 1, GOOD, 6'd0, 5'd0, 1'b0, 1'b1, c + 97);
        vectors(1, 3, -1);
        wait_idle(1);

        // Same delayed F with S=1 samples too early
        mode = 2;
        issue(0, GOOD, c);
        expect_done(0, 0, GOOD, 6'd0, 5'd0, 1'b0, 1'b0, c + 33);
        wait_idle(0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
